game_state_controller: RTL and testbench
========================================

Name: game_state_controller

Overview:
- Parametrised successor to the fixed top-level game state; the top-level currently ties game_state to PLAYING and leaves tilemap_dots undriven.
- Owns the game FSM, dot/big-dot tilemaps, score, lives, frightened timer, and player-vs-N-ghost collision.
- Sits between the character controllers (which supply positions) and Renderer (which consumes game_state and the tilemaps).
- Advances only on a 1-cycle tick strobe.

Parameters:
NUM_GHOSTS, 4, number of ghost channels
X_W, 10, x coordinate width
Y_W, 9, y coordinate width
TILE_LOG2, 4, log2 tile size in pixels
ROWS, 30, tile rows
COLS, 40, tile cols
SCORE_W, 16, score width
LIVES_INIT, 3, lives at game start (fits 3-bit lives)
HIT_DIST, 8, collision threshold in pixels per axis
DOT_PTS, 10, points per dot
BIG_DOT_PTS, 50, points per big dot
GHOST_PTS, 200, points per eaten ghost
FRIGHT_TICKS, 500, frightened duration in ticks
DEATH_TICKS, 200, dying pause in ticks

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
tick  in  1  one-clk game-step strobe (100 Hz domain pulse)
start  in  1  start/restart request, sampled on tick
player_x  in  X_W  player top-left x
player_y  in  Y_W  player top-left y
ghost_x  in  NUM_GHOSTS*X_W  ghost x, ghost i at [i*X_W +: X_W]
ghost_y  in  NUM_GHOSTS*Y_W  ghost y, same packing
dots_init  in  ROWS*COLS  dot map loaded at IDLE
big_dots_init  in  ROWS*COLS  big-dot map loaded at IDLE
game_state  out  3  FSM state code
tilemap_dots  out  ROWS*COLS  live dot map
tilemap_big_dots  out  ROWS*COLS  live big-dot map
score  out  SCORE_W  current score
lives  out  3  remaining lives
frightened  out  1  high while frightened timer is nonzero
ghost_eaten  out  NUM_GHOSTS  one-clk pulse per eaten ghost
entity_reset  out  1  one-clk pulse: controllers respawn

Behaviour:
- Clock: single clock clk. Reset: reset, asynchronous, active-low.
- Reset values: IDLE state, maps zero, score 0, lives LIVES_INIT, timers 0, all pulse outputs 0.
- All outputs are registered. Every state change happens on the clk edge where tick=1. Pulse outputs last exactly 1 clk.
- States: IDLE=0, PLAYING=1, DYING=2, GAME_OVER=3, WIN=4.
- IDLE:
  - Every clk: load both maps from the init inputs; score=0; lives=LIVES_INIT; dots_left = popcount(dots_init | big_dots_init).
  - tick&start -> PLAYING, with an entity_reset pulse.
- PLAYING (per tick):
  - Player tile idx = ((player_y+TILE/2)>>TILE_LOG2)*COLS + ((player_x+TILE/2)>>TILE_LOG2).
  - idx >= ROWS*COLS is ignored.
  - Dot bit set: clear it, score += DOT_PTS, dots_left -= 1.
  - Big-dot bit set: clear it, score += BIG_DOT_PTS, dots_left -= 1, fright timer reloads FRIGHT_TICKS (reload even if already active).
  - If no reload this tick, fright timer decrements when nonzero.
  - Ghost i hit when |px-gx|<HIT_DIST and |py-gy|<HIT_DIST; compare unsigned, compute the difference as max-min.
  - Hit while frightened: ghost_eaten[i] pulses and score += GHOST_PTS per hit ghost; simultaneous hits each score.
  - Hit while not frightened: lives -= 1, state -> DYING, fright timer cleared.
- PLAYING priority within one tick:
  - Dot scoring is always applied.
  - If dots_left reaches 0 -> WIN, which overrides a death in the same tick.
  - Otherwise a death overrides ghost eating.
- Score arithmetic: sums are computed SCORE_W+1 wide and saturate at all-ones.
- DYING: counts DEATH_TICKS ticks, then:
  - lives==0 -> GAME_OVER;
  - otherwise -> PLAYING with an entity_reset pulse. Maps and score are retained.
- GAME_OVER / WIN: hold all values; tick&start -> IDLE.
- Reset mid-game: immediate return to the reset state. Maps are reloaded on the next clk in IDLE.

Optional Feature:
- Macro: GAME_EXTRA_LIFE_EN.
- Defined: adds parameter EXTRA_LIFE_SCORE (default 10000). The first time score goes from below to at-or-above it, lives += 1, saturating at 7. Once per game; the flag is cleared in IDLE.
- Undefined: no extra lives, and no flag register exists.

Decomposition:
- define.v holds GAME_STATE_IDLE/PLAYING/DYING/GAME_OVER/WIN codes and the tile geometry defaults (tile_row_num, tile_col_num, TILE_LOG2).
- One sub-module: ghost_hit_detector (per-ghost unsigned abs-distance compare), instantiated NUM_GHOSTS times via generate; it drives a NUM_GHOSTS hit vector.

Test Plan:
- Reset low mid-PLAYING with score 120 -> next clk: state 0, score 0, lives 3, maps 0; after reset release, tilemap_dots equals dots_init after 1 clk.
- IDLE, start=1 with tick -> game_state=1 and entity_reset high for 1 clk. Player at (16,16) over a dot at idx 41 -> bit 41 cleared, score 10.
- Big dot eaten, then ghost0 at player+(3,3) -> frightened=1, ghost_eaten=0001, score +250. After 500 ticks with no big dot, frightened=0.
- Non-frightened hit with lives=1 -> DYING, lives 0; after 200 ticks -> game_state=3. Then start&tick -> 0.
- Last dot eaten in the same tick as a non-frightened hit -> game_state=4, lives unchanged.
- Score preset near saturation (SCORE_W=8, score 250, DOT_PTS=10) -> score 255. With GAME_EXTRA_LIFE_EN and threshold 100, crossing to 100 -> lives +1 once only.

Source files
------------

// File: rtl/game_state_controller_pkg.sv
// Shared state codes and tile-geometry defaults for the game state controller.
package game_state_controller_pkg;

    typedef enum logic [2:0] {
        GAME_STATE_IDLE      = 3'd0,
        GAME_STATE_PLAYING   = 3'd1,
        GAME_STATE_DYING     = 3'd2,
        GAME_STATE_GAME_OVER = 3'd3,
        GAME_STATE_WIN       = 3'd4
    } game_state_t;

    localparam int TILE_ROW_NUM  = 30;
    localparam int TILE_COL_NUM  = 40;
    localparam int TILE_LOG2_DEF = 4;

endpackage

// File: rtl/game_state_controller_ghost_hit_detector.sv
// Player-vs-one-ghost collision: unsigned per-axis distance below HIT_DIST.
module ghost_hit_detector #(
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int HIT_DIST = 8
) (
    input  logic [X_W-1:0] player_x,
    input  logic [Y_W-1:0] player_y,
    input  logic [X_W-1:0] ghost_x,
    input  logic [Y_W-1:0] ghost_y,
    output logic           hit
);
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;

    // max-min keeps the difference unsigned without a sign bit
    assign dx  = (player_x > ghost_x) ? player_x - ghost_x : ghost_x - player_x;
    assign dy  = (player_y > ghost_y) ? player_y - ghost_y : ghost_y - player_y;
    assign hit = (dx < X_W'(HIT_DIST)) && (dy < Y_W'(HIT_DIST));

endmodule

// File: rtl/game_state_controller.sv
// Game FSM: tilemaps, score, lives, frightened timer and ghost collisions, stepped by tick.
// Optional extra life at a score threshold when GAME_EXTRA_LIFE_EN is defined.
//   state     | meaning
//   IDLE      | maps/score/lives reloaded every clk, wait for start
//   PLAYING   | eat dots, resolve ghost hits
//   DYING     | DEATH_TICKS pause after losing a life
//   GAME_OVER | no lives left, hold until start
//   WIN       | all dots eaten, hold until start
module game_state_controller
    import game_state_controller_pkg::*;
#(
    parameter int NUM_GHOSTS   = 4,
    parameter int X_W          = 10,
    parameter int Y_W          = 9,
    parameter int TILE_LOG2    = TILE_LOG2_DEF,
    parameter int ROWS         = TILE_ROW_NUM,
    parameter int COLS         = TILE_COL_NUM,
    parameter int SCORE_W      = 16,
    parameter int LIVES_INIT   = 3,
    parameter int HIT_DIST     = 8,
    parameter int DOT_PTS      = 10,
    parameter int BIG_DOT_PTS  = 50,
    parameter int GHOST_PTS    = 200,
    parameter int FRIGHT_TICKS = 500,
    parameter int DEATH_TICKS  = 200
`ifdef GAME_EXTRA_LIFE_EN
   ,parameter int EXTRA_LIFE_SCORE = 10000
`endif
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       tick,
    input  logic                       start,
    input  logic [X_W-1:0]             player_x,
    input  logic [Y_W-1:0]             player_y,
    input  logic [NUM_GHOSTS*X_W-1:0]  ghost_x,
    input  logic [NUM_GHOSTS*Y_W-1:0]  ghost_y,
    input  logic [ROWS*COLS-1:0]       dots_init,
    input  logic [ROWS*COLS-1:0]       big_dots_init,
    output logic [2:0]                 game_state,
    output logic [ROWS*COLS-1:0]       tilemap_dots,
    output logic [ROWS*COLS-1:0]       tilemap_big_dots,
    output logic [SCORE_W-1:0]         score,
    output logic [2:0]                 lives,
    output logic                       frightened,
    output logic [NUM_GHOSTS-1:0]      ghost_eaten,
    output logic                       entity_reset
);
    localparam int TILE     = 1 << TILE_LOG2;
    localparam int MAP_N    = ROWS * COLS;
    localparam int IDX_W    = $clog2(MAP_N);
    localparam int DOTS_W   = $clog2(MAP_N + 1);
    localparam int FRIGHT_W = $clog2(FRIGHT_TICKS + 1);
    localparam int DEATH_W  = $clog2(DEATH_TICKS + 1);
    localparam int SW1      = SCORE_W + 1;

    game_state_t           state_q;
    logic [DOTS_W-1:0]     dots_left;
    logic [FRIGHT_W-1:0]   fright_cnt, fright_play;
    logic [DEATH_W-1:0]    death_cnt;
    logic [NUM_GHOSTS-1:0] hit, eat;
    logic [31:0]           row, col, idx;
    logic [IDX_W-1:0]      tile;
    logic                  dot_hit, big_hit, win, death;
    logic [SCORE_W-1:0]    score_play;
    logic [2:0]            lives_play;
`ifdef GAME_EXTRA_LIFE_EN
    localparam logic [SCORE_W:0] XL_THR = SW1'(EXTRA_LIFE_SCORE);
    logic xl_flag, xl_hit;
`endif

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input int unsigned b);
        logic [SCORE_W:0] s;
        s = {1'b0, a} + SW1'(b);
        return s[SCORE_W] ? '1 : s[SCORE_W-1:0];
    endfunction

    function automatic logic [DOTS_W-1:0] popcount(input logic [MAP_N-1:0] m);
        logic [DOTS_W-1:0] c;
        c = '0;
        for (int i = 0; i < MAP_N; i++) c = c + DOTS_W'(m[i]);
        return c;
    endfunction

    for (genvar g = 0; g < NUM_GHOSTS; g++) begin : g_hit
        ghost_hit_detector #(.X_W(X_W), .Y_W(Y_W), .HIT_DIST(HIT_DIST)) u_hit (
            .player_x (player_x),
            .player_y (player_y),
            .ghost_x  (ghost_x[g*X_W +: X_W]),
            .ghost_y  (ghost_y[g*Y_W +: Y_W]),
            .hit      (hit[g])
        );
    end

    assign game_state = state_q;

    always_comb begin
        row     = (32'(player_y) + 32'(TILE / 2)) >> TILE_LOG2;
        col     = (32'(player_x) + 32'(TILE / 2)) >> TILE_LOG2;
        idx     = row * 32'(COLS) + col;
        tile    = idx[IDX_W-1:0];
        dot_hit = (idx < 32'(MAP_N)) && tilemap_dots[tile];
        big_hit = (idx < 32'(MAP_N)) && tilemap_big_dots[tile];
        eat     = frightened ? hit : '0;
        death   = (|hit) && !frightened;
        // a dot and a big dot on the same tile count as one map entry
        win     = (dot_hit || big_hit) && (dots_left == DOTS_W'(1));

        score_play = score;
        if (dot_hit) score_play = sat_add(score_play, DOT_PTS);
        if (big_hit) score_play = sat_add(score_play, BIG_DOT_PTS);
        for (int g = 0; g < NUM_GHOSTS; g++)
            if (eat[g]) score_play = sat_add(score_play, GHOST_PTS);

        if (big_hit)                fright_play = FRIGHT_W'(FRIGHT_TICKS);
        else if (fright_cnt != '0)  fright_play = fright_cnt - FRIGHT_W'(1);
        else                        fright_play = '0;
        if (death && !win) fright_play = '0;

        lives_play = lives;
        if (death && !win) lives_play = (lives != 3'd0) ? lives - 3'd1 : 3'd0;
`ifdef GAME_EXTRA_LIFE_EN
        xl_hit = !xl_flag && ({1'b0, score} < XL_THR) && ({1'b0, score_play} >= XL_THR);
        if (xl_hit && lives_play != 3'd7) lives_play = lives_play + 3'd1;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= GAME_STATE_IDLE;
            tilemap_dots     <= '0;
            tilemap_big_dots <= '0;
            score            <= '0;
            lives            <= 3'(LIVES_INIT);
            dots_left        <= '0;
            fright_cnt       <= '0;
            frightened       <= 1'b0;
            death_cnt        <= '0;
            ghost_eaten      <= '0;
            entity_reset     <= 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
            xl_flag          <= 1'b0;
`endif
        end else begin
            ghost_eaten  <= '0;
            entity_reset <= 1'b0;
            case (state_q)
                GAME_STATE_IDLE: begin
                    tilemap_dots     <= dots_init;
                    tilemap_big_dots <= big_dots_init;
                    score            <= '0;
                    lives            <= 3'(LIVES_INIT);
                    dots_left        <= popcount(dots_init | big_dots_init);
                    fright_cnt       <= '0;
                    frightened       <= 1'b0;
`ifdef GAME_EXTRA_LIFE_EN
                    xl_flag          <= 1'b0;
`endif
                    if (tick && start) begin
                        state_q      <= GAME_STATE_PLAYING;
                        entity_reset <= 1'b1;
                    end
                end
                GAME_STATE_PLAYING: if (tick) begin
                    if (dot_hit) tilemap_dots[tile] <= 1'b0;
                    if (big_hit) tilemap_big_dots[tile] <= 1'b0;
                    if (dot_hit || big_hit) dots_left <= dots_left - DOTS_W'(1);
                    score       <= score_play;
                    lives       <= lives_play;
                    fright_cnt  <= fright_play;
                    frightened  <= (fright_play != '0);
                    ghost_eaten <= eat;
`ifdef GAME_EXTRA_LIFE_EN
                    if (xl_hit) xl_flag <= 1'b1;
`endif
                    if (win) begin
                        state_q <= GAME_STATE_WIN;
                    end else if (death) begin
                        state_q   <= GAME_STATE_DYING;
                        death_cnt <= DEATH_W'(DEATH_TICKS);
                    end
                end
                GAME_STATE_DYING: if (tick) begin
                    if (death_cnt <= DEATH_W'(1)) begin
                        if (lives == 3'd0) begin
                            state_q <= GAME_STATE_GAME_OVER;
                        end else begin
                            state_q      <= GAME_STATE_PLAYING;
                            entity_reset <= 1'b1;
                        end
                    end else begin
                        death_cnt <= death_cnt - DEATH_W'(1);
                    end
                end
                GAME_STATE_GAME_OVER, GAME_STATE_WIN: begin
                    if (tick && start) state_q <= GAME_STATE_IDLE;
                end
                default: state_q <= GAME_STATE_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_state_controller.sv
// Scoreboard bench: stimulus queues expected values, a monitor compares them after the clock edge.
module tb_game_state_controller;

    localparam int MAP_N = 30 * 40;

    logic              clk = 1'b0;
    logic              reset;
    logic              tick, start;
    logic [9:0]        player_x;
    logic [8:0]        player_y;
    logic [39:0]       ghost_x;
    logic [35:0]       ghost_y;
    logic [MAP_N-1:0]  dots_init, big_dots_init;
    logic [2:0]        game_state;
    logic [MAP_N-1:0]  tilemap_dots, tilemap_big_dots;
    logic [15:0]       score;
    logic [2:0]        lives;
    logic              frightened;
    logic [3:0]        ghost_eaten;
    logic              entity_reset;

    logic              tick2, start2;
    logic [9:0]        player_x2;
    logic [8:0]        player_y2;
    logic [9:0]        ghost_x2;
    logic [8:0]        ghost_y2;
    logic [7:0]        dots_init2, big_dots_init2;
    logic [2:0]        game_state2;
    logic [7:0]        tilemap_dots2, tilemap_big_dots2;
    logic [7:0]        score2;
    logic [2:0]        lives2;
    logic              frightened2;
    logic [0:0]        ghost_eaten2;
    logic              entity_reset2;

    always #5 clk = ~clk;

    game_state_controller dut (
        .clk(clk), .reset(reset), .tick(tick), .start(start),
        .player_x(player_x), .player_y(player_y),
        .ghost_x(ghost_x), .ghost_y(ghost_y),
        .dots_init(dots_init), .big_dots_init(big_dots_init),
        .game_state(game_state), .tilemap_dots(tilemap_dots),
        .tilemap_big_dots(tilemap_big_dots), .score(score), .lives(lives),
        .frightened(frightened), .ghost_eaten(ghost_eaten),
        .entity_reset(entity_reset)
    );

    game_state_controller #(
        .NUM_GHOSTS(1), .ROWS(2), .COLS(4), .SCORE_W(8),
        .DOT_PTS(10), .BIG_DOT_PTS(240)
`ifdef GAME_EXTRA_LIFE_EN
       ,.EXTRA_LIFE_SCORE(100)
`endif
    ) dut2 (
        .clk(clk), .reset(reset), .tick(tick2), .start(start2),
        .player_x(player_x2), .player_y(player_y2),
        .ghost_x(ghost_x2), .ghost_y(ghost_y2),
        .dots_init(dots_init2), .big_dots_init(big_dots_init2),
        .game_state(game_state2), .tilemap_dots(tilemap_dots2),
        .tilemap_big_dots(tilemap_big_dots2), .score(score2), .lives(lives2),
        .frightened(frightened2), .ghost_eaten(ghost_eaten2),
        .entity_reset(entity_reset2)
    );

    typedef struct {
        int          due;
        int          sel;
        logic [63:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   ncyc   = 0;
    int   errors = 0;
    int   checks = 0;

    function automatic logic [63:0] actual(input int sel);
        case (sel)
            0:  return 64'(game_state);
            1:  return 64'(score);
            2:  return 64'(lives);
            3:  return 64'(frightened);
            4:  return 64'(ghost_eaten);
            5:  return 64'(entity_reset);
            6:  return 64'(tilemap_dots[41]);
            7:  return 64'(tilemap_big_dots[43]);
            8:  return 64'((tilemap_dots == '0) && (tilemap_big_dots == '0));
            9:  return 64'((tilemap_dots == dots_init) && (tilemap_big_dots == big_dots_init));
            10: return 64'(score2);
            11: return 64'(game_state2);
            12: return 64'(lives2);
            default: return 64'hDEAD;
        endcase
    endfunction

    // monitor: values settle at posedge, compared at the following negedge
    initial begin
        exp_t e;
        logic [63:0] a;
        forever begin
            @(posedge clk);
            ncyc++;
            @(negedge clk);
            while (sb.size() > 0 && sb[0].due <= ncyc) begin
                e = sb.pop_front();
                a = actual(e.sel);
                checks++;
                if (a !== e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, a, e.exp, ncyc);
                end
            end
        end
    end

    task automatic chk(input int sel, input longint v, input string nm);
        exp_t e;
        e.due  = ncyc + 1;
        e.sel  = sel;
        e.exp  = 64'(v);
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic adv(input bit t, input bit s);
        tick  = t;
        start = s;
        @(negedge clk);
        tick  = 1'b0;
        start = 1'b0;
    endtask

    task automatic adv2(input bit t, input bit s);
        tick2  = t;
        start2 = s;
        @(negedge clk);
        tick2  = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) adv(1'b1, 1'b0);
    endtask

    task automatic set_ghost(input int i, input int x, input int y);
        ghost_x[i*10 +: 10] = 10'(x);
        ghost_y[i*9 +: 9]   = 9'(y);
    endtask

    task automatic ghosts_far();
        for (int i = 0; i < 4; i++) set_ghost(i, 900, 450);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; tick = 1'b0; start = 1'b0;
        tick2 = 1'b0; start2 = 1'b0;
        player_x = '0; player_y = '0;
        ghosts_far();
        dots_init = '0; big_dots_init = '0;
        dots_init[41] = 1'b1; dots_init[42] = 1'b1; dots_init[100] = 1'b1;
        big_dots_init[43] = 1'b1;
        player_x2 = '0; player_y2 = '0; ghost_x2 = 10'd900; ghost_y2 = 9'd450;
        dots_init2 = 8'b0000_1110; big_dots_init2 = 8'b0000_0001;

        @(negedge clk);
        chk(0, 0, "rst_state"); chk(1, 0, "rst_score"); chk(2, 3, "rst_lives");
        chk(8, 1, "rst_maps_zero"); chk(5, 0, "rst_entity_reset"); chk(3, 0, "rst_frightened");
        adv(0, 0);
        reset = 1'b1;
        chk(9, 1, "idle_map_load");
        adv(0, 0);

        chk(0, 1, "start_state"); chk(5, 1, "start_entity_reset");
        adv(1, 1);
        chk(5, 0, "entity_reset_pulse_end"); chk(0, 1, "still_playing");
        adv(0, 0);

        player_x = 10'd16; player_y = 9'd16;
        chk(6, 0, "dot41_cleared"); chk(1, 10, "dot_score");
        adv(1, 0);

        player_x = 10'd48;
        chk(7, 0, "big43_cleared"); chk(1, 60, "big_dot_score"); chk(3, 1, "frightened_set");
        adv(1, 0);

        set_ghost(0, 51, 19);
        chk(4, 1, "ghost0_eaten"); chk(1, 260, "ghost_score"); chk(0, 1, "eat_no_death");
        adv(1, 0);
        ghosts_far();
        chk(4, 0, "ghost_eaten_pulse_end");
        adv(0, 0);

        ticks(497);
        chk(3, 1, "frightened_tick499");
        adv(1, 0);
        chk(3, 0, "frightened_tick500");
        adv(1, 0);

        set_ghost(1, 56, 16);
        chk(0, 1, "dist8_no_hit"); chk(2, 3, "dist8_lives");
        adv(1, 0);

        set_ghost(1, 41, 10);
        chk(0, 2, "death1_state"); chk(2, 2, "death1_lives"); chk(3, 0, "death1_fright");
        adv(1, 0);
        ghosts_far();
        ticks(198);
        chk(0, 2, "dying_tick199");
        adv(1, 0);
        chk(0, 1, "dying_tick200_playing"); chk(5, 1, "respawn_entity_reset");
        chk(1, 260, "score_retained");
        adv(1, 0);

        set_ghost(1, 41, 10);
        chk(2, 1, "death2_lives");
        adv(1, 0);
        ghosts_far();
        ticks(199);
        chk(0, 1, "death2_respawn");
        adv(1, 0);

        set_ghost(1, 41, 10);
        chk(0, 2, "death3_state"); chk(2, 0, "death3_lives");
        adv(1, 0);
        ghosts_far();
        ticks(199);
        chk(0, 3, "game_over"); chk(5, 0, "game_over_no_respawn");
        adv(1, 0);
        chk(0, 3, "game_over_hold"); chk(1, 260, "game_over_score_hold");
        adv(1, 0);
        chk(0, 0, "game_over_to_idle");
        adv(1, 1);

        dots_init = '0; big_dots_init = '0;
        dots_init[41] = 1'b1; dots_init[42] = 1'b1;
        adv(0, 0);
        chk(9, 1, "game2_map_load");
        adv(0, 0);
        chk(0, 1, "game2_start"); chk(1, 0, "game2_score0"); chk(2, 3, "game2_lives");
        adv(1, 1);
        player_x = 10'd16; player_y = 9'd480;
        chk(1, 0, "idx_out_of_range");
        adv(1, 0);
        player_y = 9'd16;
        chk(1, 10, "game2_dot41");
        adv(1, 0);
        player_x = 10'd32;
        set_ghost(2, 32, 16);
        chk(0, 4, "win_over_death"); chk(2, 3, "win_lives_kept"); chk(1, 20, "win_score");
        adv(1, 0);
        ghosts_far();
        chk(0, 4, "win_hold");
        adv(1, 0);
        chk(0, 0, "win_to_idle");
        adv(1, 1);

        adv(0, 0);
        chk(0, 1, "game3_start");
        adv(1, 1);
        player_x = 10'd16;
        chk(1, 10, "game3_dot41");
        adv(1, 0);
        reset = 1'b0;
        chk(0, 0, "midgame_rst_state"); chk(1, 0, "midgame_rst_score");
        chk(2, 3, "midgame_rst_lives"); chk(8, 1, "midgame_rst_maps");
        adv(0, 0);
        reset = 1'b1;
        chk(9, 1, "post_rst_map_load");
        adv(0, 0);

        chk(11, 1, "sat_start");
        adv2(1, 1);
        chk(10, 240, "sat_big_dot");
`ifdef GAME_EXTRA_LIFE_EN
        chk(12, 4, "extra_life_gain");
`else
        chk(12, 3, "no_extra_life");
`endif
        adv2(1, 0);
        player_x2 = 10'd16;
        chk(10, 250, "sat_dot_250");
        adv2(1, 0);
        player_x2 = 10'd32;
        chk(10, 255, "sat_clamp_255");
`ifdef GAME_EXTRA_LIFE_EN
        chk(12, 4, "extra_life_once");
`else
        chk(12, 3, "lives_unchanged");
`endif
        adv2(1, 0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: %0d pending checks, required 0", sb.size());
            errors += sb.size();
            checks += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
